vma_queue: RTL and testbench

//  Parametrised Virtual Memory Address queue. Captures VMA descriptors (address + cycle

---
 rtl/vma_pkg.sv | 22 ++
 rtl/vma_fifo.sv | 52 +++++
 rtl/vma_queue.sv | 78 +++++++
 tb/tb_vma_queue.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vma_pkg.sv
// Shared descriptor layout for the VMA queue: {addr, cyc, flags}, with flags in the low bits.
package vma_pkg;
   localparam int CYC_W = 4;

   localparam int CYC_READ     = 3;
   localparam int CYC_WRTEST   = 2;
   localparam int CYC_WRITE    = 1;
   localparam int CYC_CACHEINH = 0;

   localparam int FLAG_USER   = 7;
   localparam int FLAG_FETCH  = 6;
   localparam int FLAG_PHYS   = 5;
   localparam int FLAG_PREV   = 4;
   localparam int FLAG_IO     = 3;
   localparam int FLAG_WRU    = 2;
   localparam int FLAG_VECT   = 1;
   localparam int FLAG_IOBYTE = 0;

   function automatic int desc_w(input int addr_w, input int flag_w);
      return addr_w + CYC_W + flag_w;
   endfunction
endpackage

// File: rtl/vma_fifo.sv
// Generic DEPTH x W register FIFO with flush.
// push/pop/flush arrive already qualified by the clock enable.
module vma_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (flush) begin
         // Drop every unissued entry; storage contents are don't-care once the head catches up.
         r_head  <= r_tail;
         r_count <= '0;
      end else begin
         if (push) begin
            r_mem[r_tail] <= din;
            r_tail        <= r_tail + 1'b1;
         end
         if (pop) r_head <= r_head + 1'b1;
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_head];
   assign count = r_count;
   assign full  = (r_count == CNT_W'(DEPTH));
endmodule

// File: rtl/vma_queue.sv
// Virtual memory address queue between microcode VMA load and the bus arbiter.
// Adds auto-increment addressing, page-fail flush, last-descriptor readback and a load strobe.
module vma_queue
   import vma_pkg::*;
#(
   parameter int ADDR_W = 20,
   parameter int DEPTH  = 4,
   parameter int FLAG_W = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clken,
   input  logic                           ld,
   input  logic                           ld_inc,
   input  logic [ADDR_W-1:0]              ld_addr,
   input  logic [CYC_W-1:0]               ld_cyc,
   input  logic [FLAG_W-1:0]              ld_flags,
   input  logic                           page_fail,
   output logic [ADDR_W+CYC_W+FLAG_W-1:0] vma_cur,
   output logic                           hd_valid,
   output logic [ADDR_W+CYC_W+FLAG_W-1:0] hd_desc,
   input  logic                           hd_ack,
   output logic                           full,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           vma_load
);
   localparam int DESC_W = desc_w(ADDR_W, FLAG_W);

   logic [DESC_W-1:0] r_cur;
   logic              r_vma_load;
   logic [ADDR_W-1:0] w_cur_addr;
   logic [ADDR_W-1:0] w_new_addr;
   logic [DESC_W-1:0] w_desc;
   logic              w_full;
   logic              w_hd_valid;
   logic              w_pop;
   logic              w_accept;
   logic              w_flush;
   logic [$clog2(DEPTH):0] w_count;

   assign w_cur_addr = r_cur[DESC_W-1 -: ADDR_W];
   assign w_new_addr = ld_inc ? (w_cur_addr + ADDR_W'(1)) : ld_addr;
   assign w_desc     = {w_new_addr, ld_cyc, ld_flags};

   assign w_hd_valid = (w_count != '0);
   // A page fail wins over both ack and load: nothing is issued or enqueued that cycle.
   assign w_flush  = clken & page_fail;
   assign w_pop    = clken & ~page_fail & w_hd_valid & hd_ack;
   assign w_accept = clken & ld & ~page_fail & (~w_full | (w_hd_valid & hd_ack));

   vma_fifo #(.DEPTH(DEPTH), .W(DESC_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_accept),
      .pop   (w_pop),
      .flush (w_flush),
      .din   (w_desc),
      .dout  (hd_desc),
      .count (w_count),
      .full  (w_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cur      <= '0;
         r_vma_load <= 1'b0;
      end else if (clken) begin
         r_vma_load <= ld;
         if (w_accept) r_cur <= w_desc;
      end
   end

   assign vma_cur  = r_cur;
   assign vma_load = r_vma_load;
   assign hd_valid = w_hd_valid;
   assign full     = w_full;
   assign count    = w_count;
endmodule

// File: tb/tb_vma_queue.sv
// Scoreboard bench for vma_queue (ADDR_W=20, DEPTH=4, FLAG_W=8).
module tb_vma_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clken = 1'b1;
   logic        ld = 1'b0, ld_inc = 1'b0;
   logic [19:0] ld_addr = '0;
   logic [3:0]  ld_cyc = '0;
   logic [7:0]  ld_flags = '0;
   logic        page_fail = 1'b0;
   logic        hd_ack = 1'b0;
   logic [31:0] vma_cur, hd_desc;
   logic        hd_valid, full, vma_load;
   logic [2:0]  count;

   int n_checks = 0;
   int n_err    = 0;
   logic [31:0] exp_q[$];

   localparam logic [3:0] RD = 4'b1000, WR = 4'b0010;

   always #5 clk = ~clk;

   vma_queue #(.ADDR_W(20), .DEPTH(4), .FLAG_W(8)) dut (
      .clk(clk), .rst(rst), .clken(clken), .ld(ld), .ld_inc(ld_inc),
      .ld_addr(ld_addr), .ld_cyc(ld_cyc), .ld_flags(ld_flags),
      .page_fail(page_fail), .vma_cur(vma_cur), .hd_valid(hd_valid),
      .hd_desc(hd_desc), .hd_ack(hd_ack), .full(full), .count(count),
      .vma_load(vma_load)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic l, input logic li, input logic [19:0] a,
                        input logic [3:0] c, input logic [7:0] f,
                        input logic ack, input logic pf);
      ld = l; ld_inc = li; ld_addr = a; ld_cyc = c; ld_flags = f;
      hd_ack = ack; page_fail = pf;
      @(posedge clk); #1;
      ld = 1'b0; ld_inc = 1'b0; hd_ack = 1'b0; page_fail = 1'b0;
   endtask

   // Monitor: every real dequeue must present the oldest expected descriptor.
   always @(negedge clk) begin
      if (!rst && clken && !page_fail && hd_valid && hd_ack) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL deq_unexpected: got %h expected none", hd_desc);
         end else begin
            chk("deq_desc", {32'd0, hd_desc}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      @(posedge clk); @(posedge clk); #1;
      chk("rst_count", count, 0);
      chk("rst_valid", hd_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_cur", vma_cur, 0);
      chk("rst_load", vma_load, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: single load, visible next cycle
      exp_q.push_back({20'h00100, RD, 8'h80});
      drive(1, 0, 20'h00100, RD, 8'h80, 0, 0);
      chk("t1_valid", hd_valid, 1);
      chk("t1_addr", hd_desc[31:12], 20'h00100);
      chk("t1_count", count, 1);
      chk("t1_load", vma_load, 1);
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("t1_empty", hd_valid, 0);
      chk("t1_load_clr", vma_load, 0);

      // 2: fill to DEPTH, fifth dropped
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_q.push_back({20'h00010 + 20'(i), WR, 8'h40});
         drive(1, 0, 20'h00010 + 20'(i), WR, 8'h40, 0, 0);
      end
      chk("t2_count", count, 4);
      chk("t2_full", full, 1);
      chk("t2_cur", vma_cur, {20'h00013, WR, 8'h40});

      // 3: load + ack while full
      exp_q.push_back({20'h00020, RD, 8'h01});
      drive(1, 0, 20'h00020, RD, 8'h01, 1, 0);
      chk("t3_count", count, 4);
      chk("t3_full", full, 1);
      chk("t3_head", hd_desc[31:12], 20'h00011);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0);
      chk("t3_drained", hd_valid, 0);
      chk("t3_count0", count, 0);

      // 4: increment wrap
      exp_q.push_back({20'hFFFFF, RD, 8'h02});
      drive(1, 0, 20'hFFFFF, RD, 8'h02, 0, 0);
      exp_q.push_back({20'h00000, WR, 8'h04});
      drive(1, 1, 20'h12345, WR, 8'h04, 0, 0);
      exp_q.push_back({20'h00001, RD, 8'h08});
      drive(1, 1, 20'h54321, RD, 8'h08, 0, 0);
      chk("t4_cur", vma_cur, {20'h00001, RD, 8'h08});
      chk("t4_count", count, 3);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1, 0);

      // 5: page fail flush
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({20'h00030 + 20'(i), WR, 8'h10});
         drive(1, 0, 20'h00030 + 20'(i), WR, 8'h10, 0, 0);
      end
      drive(1, 0, 20'h00099, RD, 8'hFF, 1, 1);
      exp_q.delete();
      chk("t5_count", count, 0);
      chk("t5_valid", hd_valid, 0);
      chk("t5_cur", vma_cur, {20'h00032, WR, 8'h10});
      exp_q.push_back({20'h00040, RD, 8'h20});
      drive(1, 0, 20'h00040, RD, 8'h20, 0, 0);
      chk("t5_head_after", hd_desc, {20'h00040, RD, 8'h20});
      drive(0, 0, 0, 0, 0, 1, 0);

      // 6: clock enable low, then async reset mid-stream
      exp_q.push_back({20'h00050, RD, 8'h80});
      drive(1, 0, 20'h00050, RD, 8'h80, 0, 0);
      clken = 1'b0;
      drive(1, 0, 20'h00077, WR, 8'h01, 1, 0);
      drive(0, 1, 20'h00078, WR, 8'h01, 1, 1);
      chk("t6_count", count, 1);
      chk("t6_head", hd_desc, {20'h00050, RD, 8'h80});
      chk("t6_cur", vma_cur, {20'h00050, RD, 8'h80});
      chk("t6_load_hold", vma_load, 1);
      clken = 1'b1;
      exp_q.push_back({20'h00060, WR, 8'h02});
      drive(1, 0, 20'h00060, WR, 8'h02, 0, 0);
      chk("t6_count2", count, 2);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      chk("t6_rst_count", count, 0);
      chk("t6_rst_valid", hd_valid, 0);
      chk("t6_rst_cur", vma_cur, 0);
      chk("t6_rst_load", vma_load, 0);
      @(posedge clk); #1 rst = 1'b0;
      exp_q.push_back({20'h00070, RD, 8'h04});
      drive(1, 0, 20'h00070, RD, 8'h04, 0, 0);
      chk("t6_post_head", hd_desc, {20'h00070, RD, 8'h04});
      drive(0, 0, 0, 0, 0, 1, 0);
      chk("final_valid", hd_valid, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
